// File: rtl/axis_multi_chan_perf_mon.sv
// Passive multi-channel AXI-Stream performance monitor: counts cycles, beats,
// bytes, packets and stalls per channel over a measurement window and snapshots them.
module axis_multi_chan_perf_mon #(
   parameter int NUM_CH = 2,
   parameter int KEEP_W = 64,
   parameter int CNT_W  = 32,
   parameter int BYTE_W = 40
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic [NUM_CH-1:0]        mon_tvalid,
   input  logic [NUM_CH-1:0]        mon_tready,
   input  logic [NUM_CH-1:0]        mon_tlast,
   input  logic [NUM_CH*KEEP_W-1:0] mon_tkeep,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     clear,
   input  logic [CNT_W-1:0]         window_len,
   input  logic                     trig_first,
   output logic [1:0]               state_out,
   output logic                     done,
   output logic [CNT_W-1:0]         cycle_cnt,
   output logic [NUM_CH*CNT_W-1:0]  beat_cnt,
   output logic [NUM_CH*CNT_W-1:0]  pkt_cnt,
   output logic [NUM_CH*CNT_W-1:0]  stall_cnt,
   output logic [NUM_CH*BYTE_W-1:0] byte_cnt,
   output logic [NUM_CH:0]          sat
);
   localparam int PC_W = $clog2(KEEP_W + 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           wlen_q, wlen_d;
   logic [CNT_W-1:0]           cyc_q, cyc_d, cyc_n, scyc_q, scyc_d;
   logic [NUM_CH*CNT_W-1:0]    beat_q, beat_d, beat_n, sbeat_q, sbeat_d;
   logic [NUM_CH*CNT_W-1:0]    pkt_q, pkt_d, pkt_n, spkt_q, spkt_d;
   logic [NUM_CH*CNT_W-1:0]    stall_q, stall_d, stall_n, sstall_q, sstall_d;
   logic [NUM_CH*BYTE_W-1:0]   byte_q, byte_d, byte_n, sbyte_q, sbyte_d;
   logic [NUM_CH:0]            sat_q, sat_d, sat_n;
   logic [NUM_CH-1:0]          hs, stl, sb, sp, ss, sy;
   logic                       sc, win_end, count_en, close_en;

   // Result is {overflow_flag, value}; value pins at all-ones on overflow.
   function automatic logic [CNT_W:0] cnt_inc(input logic [CNT_W-1:0] v, input logic en);
      logic [CNT_W:0] s;
      s = {1'b0, v} + (CNT_W+1)'(en);
      if (s[CNT_W]) s = {1'b1, {CNT_W{1'b1}}};
      return s;
   endfunction

   function automatic logic [BYTE_W:0] byte_add(input logic [BYTE_W-1:0] v, input logic [PC_W-1:0] n);
      logic [BYTE_W:0] s;
      s = {1'b0, v} + (BYTE_W+1)'(n);
      if (s[BYTE_W]) s = {1'b1, {BYTE_W{1'b1}}};
      return s;
   endfunction

   function automatic logic [PC_W-1:0] popcnt(input logic [KEEP_W-1:0] k);
      logic [PC_W-1:0] c;
      c = '0;
      for (int b = 0; b < KEEP_W; b++) c = c + PC_W'(k[b]);
      return c;
   endfunction

   assign hs  = mon_tvalid & mon_tready;
   assign stl = mon_tvalid & ~mon_tready;

   // Candidate counter values if the current cycle is counted.
   always_comb begin
      beat_n  = beat_q;
      pkt_n   = pkt_q;
      stall_n = stall_q;
      byte_n  = byte_q;
      sb = '0; sp = '0; ss = '0; sy = '0;
      {sc, cyc_n} = cnt_inc(cyc_q, 1'b1);
      for (int i = 0; i < NUM_CH; i++) begin
         {sb[i], beat_n[i*CNT_W +: CNT_W]}  = cnt_inc(beat_q[i*CNT_W +: CNT_W], hs[i]);
         {sp[i], pkt_n[i*CNT_W +: CNT_W]}   = cnt_inc(pkt_q[i*CNT_W +: CNT_W], hs[i] & mon_tlast[i]);
         {ss[i], stall_n[i*CNT_W +: CNT_W]} = cnt_inc(stall_q[i*CNT_W +: CNT_W], stl[i]);
         {sy[i], byte_n[i*BYTE_W +: BYTE_W]} =
            byte_add(byte_q[i*BYTE_W +: BYTE_W], hs[i] ? popcnt(mon_tkeep[i*KEEP_W +: KEEP_W]) : '0);
      end
      sat_n = sat_q | {sc, sb | sp | ss | sy};
   end

   always_comb begin
      state_d  = state_q;
      wlen_d   = wlen_q;
      cyc_d    = cyc_q;
      beat_d   = beat_q;
      pkt_d    = pkt_q;
      stall_d  = stall_q;
      byte_d   = byte_q;
      sat_d    = sat_q;
      scyc_d   = scyc_q;
      sbeat_d  = sbeat_q;
      spkt_d   = spkt_q;
      sstall_d = sstall_q;
      sbyte_d  = sbyte_q;
      count_en = 1'b0;
      close_en = 1'b0;
      win_end  = (wlen_q != '0) && (cyc_n == wlen_q);
      if (clear) begin
         state_d = S_IDLE;
         cyc_d = '0; beat_d = '0; pkt_d = '0; stall_d = '0; byte_d = '0; sat_d = '0;
         scyc_d = '0; sbeat_d = '0; spkt_d = '0; sstall_d = '0; sbyte_d = '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start && !stop) begin
                  cyc_d = '0; beat_d = '0; pkt_d = '0; stall_d = '0; byte_d = '0; sat_d = '0;
                  wlen_d  = window_len;
                  state_d = trig_first ? S_ARMED : S_RUN;
               end
            end
            S_ARMED: begin
               if (stop) begin
                  close_en = 1'b1;
               end else if (|hs) begin
                  // The triggering cycle is the first counted cycle of the window.
                  count_en = 1'b1;
                  close_en = win_end;
                  state_d  = S_RUN;
               end
            end
            S_RUN: begin
               count_en = 1'b1;
               close_en = stop | win_end;
            end
            default: state_d = S_IDLE;
         endcase
         if (count_en) begin
            cyc_d = cyc_n; beat_d = beat_n; pkt_d = pkt_n; stall_d = stall_n; byte_d = byte_n;
            sat_d = sat_n;
         end
         if (close_en) begin
            state_d = S_DONE;
            scyc_d = cyc_d; sbeat_d = beat_d; spkt_d = pkt_d; sstall_d = stall_d; sbyte_d = byte_d;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         wlen_q   <= '0;
         cyc_q    <= '0;
         beat_q   <= '0;
         pkt_q    <= '0;
         stall_q  <= '0;
         byte_q   <= '0;
         sat_q    <= '0;
         scyc_q   <= '0;
         sbeat_q  <= '0;
         spkt_q   <= '0;
         sstall_q <= '0;
         sbyte_q  <= '0;
      end else begin
         state_q  <= state_d;
         wlen_q   <= wlen_d;
         cyc_q    <= cyc_d;
         beat_q   <= beat_d;
         pkt_q    <= pkt_d;
         stall_q  <= stall_d;
         byte_q   <= byte_d;
         sat_q    <= sat_d;
         scyc_q   <= scyc_d;
         sbeat_q  <= sbeat_d;
         spkt_q   <= spkt_d;
         sstall_q <= sstall_d;
         sbyte_q  <= sbyte_d;
      end
   end

   assign state_out = state_q;
   assign done      = (state_q == S_DONE);
   assign cycle_cnt = scyc_q;
   assign beat_cnt  = sbeat_q;
   assign pkt_cnt   = spkt_q;
   assign stall_cnt = sstall_q;
   assign byte_cnt  = sbyte_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_axis_multi_chan_perf_mon.sv
// Bench for axis_multi_chan_perf_mon: window-level reference model checked every
// cycle, plus directed scenarios with hand-computed results.
module tb_axis_multi_chan_perf_mon;
   localparam int NC  = 2;
   localparam int KW  = 64;
   localparam int CW  = 32;
   localparam int BW  = 40;
   localparam int SCW = 4;
   localparam longint CMAX = 64'hFFFF_FFFF;
   localparam longint BMAX = 64'hFF_FFFF_FFFF;

   logic CLK = 1'b0;
   logic RST_N = 1'b1;
   always #5 CLK = ~CLK;

   logic [NC-1:0]    tv, tr, tl;
   logic [NC*KW-1:0] tk;
   logic             start, stop, clear, trig;
   logic [CW-1:0]    wl;
   logic [SCW-1:0]   wl_s;

   logic [1:0]       st;
   logic             dn;
   logic [CW-1:0]    ccnt;
   logic [NC*CW-1:0] bcnt, pcnt, scnt;
   logic [NC*BW-1:0] ycnt;
   logic [NC:0]      sat;

   logic [1:0]        st_s;
   logic              dn_s;
   logic [SCW-1:0]    ccnt_s;
   logic [NC*SCW-1:0] bcnt_s, pcnt_s, scnt_s;
   logic [NC*BW-1:0]  ycnt_s;
   logic [NC:0]       sat_s;

   axis_multi_chan_perf_mon #(.NUM_CH(NC), .KEEP_W(KW), .CNT_W(CW), .BYTE_W(BW)) dut (
      .CLK(CLK), .RST_N(RST_N), .mon_tvalid(tv), .mon_tready(tr), .mon_tlast(tl),
      .mon_tkeep(tk), .start(start), .stop(stop), .clear(clear), .window_len(wl),
      .trig_first(trig), .state_out(st), .done(dn), .cycle_cnt(ccnt), .beat_cnt(bcnt),
      .pkt_cnt(pcnt), .stall_cnt(scnt), .byte_cnt(ycnt), .sat(sat));

   axis_multi_chan_perf_mon #(.NUM_CH(NC), .KEEP_W(KW), .CNT_W(SCW), .BYTE_W(BW)) dut_s (
      .CLK(CLK), .RST_N(RST_N), .mon_tvalid(tv), .mon_tready(tr), .mon_tlast(tl),
      .mon_tkeep(tk), .start(start), .stop(stop), .clear(clear), .window_len(wl_s),
      .trig_first(trig), .state_out(st_s), .done(dn_s), .cycle_cnt(ccnt_s), .beat_cnt(bcnt_s),
      .pkt_cnt(pcnt_s), .stall_cnt(scnt_s), .byte_cnt(ycnt_s), .sat(sat_s));

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: window phase 0 idle, 1 waiting for trigger, 2 measuring, 3 finished.
   int     m_ph;
   longint m_wl, m_cyc, s_cyc;
   longint m_beat[NC], m_pkt[NC], m_stall[NC], m_byte[NC];
   longint s_beat[NC], s_pkt[NC], s_stall[NC], s_byte[NC];
   bit [NC:0] m_sat;

   function automatic longint sadd(input longint v, input longint n, input longint mx, input int b);
      if (v + n > mx) begin
         m_sat[b] = 1'b1;
         return mx;
      end
      return v + n;
   endfunction

   task automatic m_reset_live();
      m_cyc = 0; m_sat = '0;
      for (int c = 0; c < NC; c++) begin
         m_beat[c] = 0; m_pkt[c] = 0; m_stall[c] = 0; m_byte[c] = 0;
      end
   endtask

   task automatic m_publish();
      s_cyc = m_cyc;
      for (int c = 0; c < NC; c++) begin
         s_beat[c] = m_beat[c]; s_pkt[c] = m_pkt[c]; s_stall[c] = m_stall[c]; s_byte[c] = m_byte[c];
      end
   endtask

   task automatic m_tally();
      m_cyc = sadd(m_cyc, 1, CMAX, NC);
      for (int c = 0; c < NC; c++) begin
         if (tv[c] && tr[c]) begin
            m_beat[c] = sadd(m_beat[c], 1, CMAX, c);
            m_byte[c] = sadd(m_byte[c], $countones(tk[c*KW +: KW]), BMAX, c);
            if (tl[c]) m_pkt[c] = sadd(m_pkt[c], 1, CMAX, c);
         end
         if (tv[c] && !tr[c]) m_stall[c] = sadd(m_stall[c], 1, CMAX, c);
      end
   endtask

   initial forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N || clear) begin
         m_ph = 0; m_wl = 0;
         m_reset_live();
         m_publish();
      end else if (m_ph == 0 || m_ph == 3) begin
         if (start && !stop) begin
            m_reset_live();
            m_wl = wl;
            m_ph = trig ? 1 : 2;
         end
      end else if (m_ph == 1 && stop) begin
         m_publish();
         m_ph = 3;
      end else if (m_ph == 2 || (tv & tr) != '0) begin
         m_tally();
         m_ph = 2;
         if ((m_ph == 2 && stop) || (m_wl != 0 && m_cyc == m_wl)) begin
            m_publish();
            m_ph = 3;
         end
      end
   end

   initial forever begin
      @(negedge CLK);
      chk("state", st, m_ph);
      chk("done", dn, (m_ph == 3));
      chk("cycle_cnt", ccnt, s_cyc);
      chk("sat", sat, m_sat);
      for (int c = 0; c < NC; c++) begin
         chk($sformatf("beat%0d", c), bcnt[c*CW +: CW], s_beat[c]);
         chk($sformatf("pkt%0d", c), pcnt[c*CW +: CW], s_pkt[c]);
         chk($sformatf("stall%0d", c), scnt[c*CW +: CW], s_stall[c]);
         chk($sformatf("byte%0d", c), ycnt[c*BW +: BW], s_byte[c]);
      end
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic pulse_start(input longint len, input bit tf);
      wl = len; trig = tf; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      tv = '0; tr = '0; tl = '0; tk = '1;
      start = 1'b0; stop = 1'b0; clear = 1'b0; trig = 1'b0; wl = '0; wl_s = '0;
      #1 RST_N = 1'b0;
      step(); step();
      @(negedge CLK);
      chk("rst_state", st, 0);
      chk("rst_done", dn, 0);
      chk("rst_cycle", ccnt, 0);
      chk("rst_sat", sat, 0);
      RST_N = 1'b1;
      step();

      // 100-cycle window, ch0 streaming, tlast every 4th beat; window_len changed after start
      pulse_start(100, 1'b0);
      wl = 7;
      tv[0] = 1'b1; tr[0] = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         tl[0] = (k % 4 == 0);
         step();
      end
      tv = '0; tr = '0; tl = '0;
      @(negedge CLK);
      chk("w100_done", dn, 1);
      chk("w100_cycle", ccnt, 100);
      chk("w100_beat0", bcnt[0 +: CW], 100);
      chk("w100_byte0", ycnt[0 +: BW], 6400);
      chk("w100_pkt0", pcnt[0 +: CW], 25);
      chk("w100_beat1", bcnt[CW +: CW], 0);
      chk("w100_byte1", ycnt[BW +: BW], 0);

      // first-handshake trigger on ch1, 37 cycles after start; ch0 stalls while armed
      tk[KW +: KW] = 64'h0000_0000_0000_00FF;
      pulse_start(10, 1'b1);
      tv[0] = 1'b1;
      @(negedge CLK);
      chk("trig_armed", st, 1);
      repeat (36) step();
      tv[0] = 1'b0;
      tv[1] = 1'b1; tr[1] = 1'b1;
      repeat (12) step();
      tv = '0; tr = '0;
      @(negedge CLK);
      chk("trig_cycle", ccnt, 10);
      chk("trig_beat1", bcnt[CW +: CW], 10);
      chk("trig_byte1", ycnt[BW +: BW], 80);
      chk("trig_stall0", scnt[0 +: CW], 0);
      chk("trig_beat0", bcnt[0 +: CW], 0);

      // unbounded window, ch0 stalled 20 cycles, then stop
      pulse_start(0, 1'b0);
      tv[0] = 1'b1; tr[0] = 1'b0;
      repeat (19) step();
      stop = 1'b1;
      step();
      stop = 1'b0; tv = '0;
      @(negedge CLK);
      chk("stall_state", st, 3);
      chk("stall_cycle", ccnt, 20);
      chk("stall_cnt0", scnt[0 +: CW], 20);
      chk("stall_beat0", bcnt[0 +: CW], 0);

      // stop while still armed: finished window with zero snapshot
      pulse_start(0, 1'b1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      @(negedge CLK);
      chk("armstop_done", dn, 1);
      chk("armstop_cycle", ccnt, 0);
      chk("armstop_stall0", scnt[0 +: CW], 0);

      // 4-bit counter instance saturates after 20 handshakes
      clear = 1'b1;
      step();
      clear = 1'b0;
      pulse_start(0, 1'b0);
      tv[0] = 1'b1; tr[0] = 1'b1;
      repeat (20) step();
      tv = '0; tr = '0;
      stop = 1'b1;
      step();
      stop = 1'b0;
      @(negedge CLK);
      chk("satw_beat0_small", bcnt_s[0 +: SCW], 15);
      chk("satw_sat0_small", sat_s[0], 1);
      chk("satw_beat0_main", bcnt[0 +: CW], 20);
      chk("satw_cycle_main", ccnt, 21);
      pulse_start(0, 1'b0);
      @(negedge CLK);
      chk("satw_sat_cleared", sat_s, 0);
      chk("satw_snap_held", bcnt_s[0 +: SCW], 15);
      stop = 1'b1;
      step();
      stop = 1'b0;

      // clear and stop in the same cycle while running
      pulse_start(0, 1'b0);
      tv[0] = 1'b1; tr[0] = 1'b1;
      repeat (3) step();
      clear = 1'b1; stop = 1'b1;
      step();
      clear = 1'b0; stop = 1'b0; tv = '0; tr = '0;
      @(negedge CLK);
      chk("clrstop_state", st, 0);
      chk("clrstop_done", dn, 0);
      chk("clrstop_cycle", ccnt, 0);
      chk("clrstop_beat0", bcnt[0 +: CW], 0);

      // reset mid-window, then a clean 5-cycle window
      pulse_start(0, 1'b0);
      tv[0] = 1'b1; tr[0] = 1'b1;
      repeat (4) step();
      #1 RST_N = 1'b0;
      #1;
      chk("midrst_state", st, 0);
      chk("midrst_cycle", ccnt, 0);
      step();
      RST_N = 1'b1;
      step();
      pulse_start(5, 1'b0);
      repeat (5) step();
      tv = '0; tr = '0;
      @(negedge CLK);
      chk("postrst_done", dn, 1);
      chk("postrst_cycle", ccnt, 5);
      chk("postrst_beat0", bcnt[0 +: CW], 5);
      chk("postrst_byte0", ycnt[0 +: BW], 320);

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
